// File: rtl/sm_shift_add_mult_if.sv
// sm_shift_add_mult_if: start/done handshake and operand/product bus for sm_shift_add_mult
interface sm_shift_add_mult_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] y;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] z;
  modport master (output start, w, y, input busy, done, z);
  modport slave (input start, w, y, output busy, done, z);
endinterface

// File: rtl/sm_shift_add_mult.sv
// sm_shift_add_mult: sequential sign-magnitude shift-and-add multiplier; define MUL_EARLY_EXIT_EN to leave RUN once the multiplier empties
module sm_shift_add_mult #(parameter int WIDTH = 8) (
  input logic clk,
  input logic nrst,
  sm_shift_add_mult_if.slave bus
);
  localparam int AW = 2*WIDTH-1;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-2:0] mplier_q, mplier_d;
  logic [CW-1:0] count_q, count_d;
  logic sign_q, sign_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic last;
  // next state: latch operands on start, one shift-add step per RUN cycle, publish z on DONE entry
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    count_d = count_q;
    sign_d = sign_q;
    z_d = z_q;
    last = 1'b0;
    if (state_q == IDLE && bus.start) begin
      mcand_d = {{WIDTH{1'b0}}, bus.w[WIDTH-2:0]};
      mplier_d = bus.y[WIDTH-2:0];
      sign_d = bus.w[WIDTH-1] ^ bus.y[WIDTH-1];
      acc_d = '0;
      count_d = CW'(WIDTH-1);
      state_d = RUN;
    end else if (state_q == RUN) begin
      acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d = count_q - CW'(1);
`ifdef MUL_EARLY_EXIT_EN
      last = count_q == CW'(1) || mplier_d == '0;
`else
      last = count_q == CW'(1);
`endif
      if (last) begin
        state_d = DONE;
        z_d = {sign_q & (acc_d != '0), acc_d};
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      count_q <= '0;
      sign_q <= 1'b0;
      z_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      count_q <= count_d;
      sign_q <= sign_d;
      z_q <= z_d;
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.z = z_q;
endmodule

// File: tb/tb_sm_shift_add_mult.sv
// tb_sm_shift_add_mult: directed self-checking bench for sm_shift_add_mult at WIDTH=8
module tb_sm_shift_add_mult;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int checks = 0;
  int errors = 0;
  sm_shift_add_mult_if #(.WIDTH(8)) bus ();
  sm_shift_add_mult #(.WIDTH(8)) dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      if (bus.busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] wv, input logic [7:0] yv,
                        input logic [15:0] ez, input int eb_on);
    int nb;
    int eb;
`ifdef MUL_EARLY_EXIT_EN
    eb = eb_on;
`else
    eb = 7;
`endif
    bus.start = 1'b1;
    bus.w = wv;
    bus.y = yv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.w = 8'hxx;
    bus.y = 8'hxx;
    wait_done(nb);
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " busy@done"}, 32'(bus.busy), 32'd0);
    check({tag, " z"}, 32'(bus.z), 32'(ez));
    check({tag, " busy cycles"}, 32'(nb), 32'(eb));
    @(negedge clk);
    check({tag, " done pulse"}, 32'(bus.done), 32'd0);
    check({tag, " z hold"}, 32'(bus.z), 32'(ez));
  endtask

  initial begin
    int nb;
    int seen;
    bus.start = 1'b0;
    bus.w = '0;
    bus.y = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst z", 32'(bus.z), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    run_op("m5x7", 8'h85, 8'h07, 16'h8023, 3);
    run_op("max", 8'h7F, 8'h7F, 16'h3F01, 7);
    run_op("negzero w", 8'h80, 8'h05, 16'h0000, 3);
    run_op("negzero y", 8'h83, 8'h80, 16'h0000, 1);
    run_op("y1", 8'h09, 8'h01, 16'h0009, 1);
    // abort mid-RUN
    bus.start = 1'b1;
    bus.w = 8'h03;
    bus.y = 8'h05;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort z", 32'(bus.z), 32'd0);
    seen = 0;
    repeat (10) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    check("abort no done", 32'(seen), 32'd0);
    run_op("after abort", 8'h02, 8'h83, 16'h8006, 2);
    // start held high through RUN and DONE with changed operands
    bus.start = 1'b1;
    bus.w = 8'h02;
    bus.y = 8'h03;
    @(negedge clk);
    bus.w = 8'h7F;
    bus.y = 8'h7F;
    wait_done(nb);
    check("hold done", 32'(bus.done), 32'd1);
    check("hold z", 32'(bus.z), 32'h0006);
`ifdef MUL_EARLY_EXIT_EN
    check("hold busy cycles", 32'(nb), 32'd2);
`else
    check("hold busy cycles", 32'(nb), 32'd7);
`endif
    @(negedge clk);
    check("hold idle done", 32'(bus.done), 32'd0);
    check("hold idle busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("hold rerun busy", 32'(bus.busy), 32'd1);
    check("hold z in run", 32'(bus.z), 32'h0006);
    bus.start = 1'b0;
    wait_done(nb);
    check("hold second done", 32'(bus.done), 32'd1);
    check("hold second z", 32'(bus.z), 32'h3F01);
    @(negedge clk);
    check("hold second pulse", 32'(bus.done), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
